// File: rtl/led_pwm_bank.sv
// Memory-mapped bank of LED drivers. Each channel is either a static level or a PWM output
// driven from one shared, prescaled PWM counter. Reads have a fixed two-cycle latency.
module led_pwm_bank #(
    parameter int unsigned CHANNELS       = 6,
    parameter int unsigned PWM_WIDTH      = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic                mem_write,
    input  logic                mem_read,
    input  logic [3:0]          byte_enable,
    output logic [31:0]         read_data,
    output logic                rbusy,
    output logic [CHANNELS-1:0] led
);

    localparam logic [5:0] WordCtrl     = 6'h00;
    localparam logic [5:0] WordPrescale = 6'h01;
    localparam logic [5:0] WordMode     = 6'h02;
    localparam logic [5:0] WordStatic   = 6'h03;
    localparam logic [5:0] WordStatus   = 6'h04;
    localparam logic [5:0] WordDuty0    = 6'h08;

    localparam logic [PWM_WIDTH-1:0]      PwmOne = {{(PWM_WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_WIDTH-1:0] PreOne = {{(PRESCALE_WIDTH - 1){1'b0}}, 1'b1};

    // Configuration registers
    logic                      r_en;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [CHANNELS-1:0]       r_mode;
    logic [CHANNELS-1:0]       r_static;
    logic [PWM_WIDTH-1:0]      r_duty [CHANNELS];

    // Counters, outputs and read pipeline
    logic [PRESCALE_WIDTH-1:0] r_pre_cnt;
    logic [PWM_WIDTH-1:0]      r_pwm_cnt;
    logic [CHANNELS-1:0]       r_led;
    logic                      r_rbusy;
    logic [31:0]               r_rsample;
    logic [31:0]               r_rdata;

    logic [5:0]                w_word;
    logic                      w_wr_ctrl;
    logic                      w_wr_prescale;
    logic                      w_wr_mode;
    logic                      w_wr_static;
    logic [CHANNELS-1:0]       w_wr_duty;
    logic                      w_pre_touch;
    logic                      w_en_new;
    logic [PRESCALE_WIDTH-1:0] w_prescale_new;
    logic [CHANNELS-1:0]       w_mode_new;
    logic [CHANNELS-1:0]       w_static_new;
    logic [PWM_WIDTH-1:0]      w_duty_new [CHANNELS];
    logic                      w_tick;
    logic [PRESCALE_WIDTH-1:0] w_pre_cnt_d;
    logic [PWM_WIDTH-1:0]      w_pwm_cnt_d;
    logic [CHANNELS-1:0]       w_led_d;
    logic [31:0]               w_rmux;
    logic                      w_rd_accept;
    logic                      w_unused_bits;

    assign w_word        = mem_addr[7:2];
    assign w_wr_ctrl     = mem_write && (w_word == WordCtrl);
    assign w_wr_prescale = mem_write && (w_word == WordPrescale);
    assign w_wr_mode     = mem_write && (w_word == WordMode);
    assign w_wr_static   = mem_write && (w_word == WordStatic);
    // A write with no byte lanes enabled changes nothing, so it must not restart the counters.
    assign w_pre_touch   = w_wr_prescale && (|byte_enable);
    // A simultaneous write wins over the read; reads while busy are dropped.
    assign w_rd_accept   = mem_read && !mem_write && !r_rbusy;
    assign w_unused_bits = ^{mem_addr[1:0], mem_wdata};

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_wr_duty[i] = mem_write && (w_word == (WordDuty0 + 6'(i)));
        end
    end

    // Byte-lane merge of the write data into each register's current value.
    always_comb begin
        w_en_new = byte_enable[0] ? mem_wdata[0] : r_en;
        for (int b = 0; b < PRESCALE_WIDTH; b++) begin
            w_prescale_new[b] = byte_enable[b / 8] ? mem_wdata[b] : r_prescale[b];
        end
        for (int i = 0; i < CHANNELS; i++) begin
            w_mode_new[i]   = byte_enable[i / 8] ? mem_wdata[i] : r_mode[i];
            w_static_new[i] = byte_enable[i / 8] ? mem_wdata[i] : r_static[i];
        end
        for (int i = 0; i < CHANNELS; i++) begin
            for (int b = 0; b < PWM_WIDTH; b++) begin
                w_duty_new[i][b] = byte_enable[b / 8] ? mem_wdata[b] : r_duty[i][b];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_en       <= 1'b0;
            r_prescale <= '0;
            r_mode     <= '0;
            r_static   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i] <= '0;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_en <= w_en_new;
            end
            if (w_wr_prescale) begin
                r_prescale <= w_prescale_new;
            end
            if (w_wr_mode) begin
                r_mode <= w_mode_new;
            end
            if (w_wr_static) begin
                r_static <= w_static_new;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wr_duty[i]) begin
                    r_duty[i] <= w_duty_new[i];
                end
            end
        end
    end

    always_comb begin
        w_tick      = r_en && (r_pre_cnt == r_prescale);
        w_pre_cnt_d = r_pre_cnt + PreOne;
        w_pwm_cnt_d = r_pwm_cnt;
        if (!r_en || w_pre_touch) begin
            w_pre_cnt_d = '0;
            w_pwm_cnt_d = '0;
        end else if (w_tick) begin
            w_pre_cnt_d = '0;
            w_pwm_cnt_d = r_pwm_cnt + PwmOne;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pre_cnt <= w_pre_cnt_d;
            r_pwm_cnt <= w_pwm_cnt_d;
        end
    end

    always_comb begin
        w_led_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_led_d[i] = r_en && (r_mode[i] ? (r_duty[i] > r_pwm_cnt) : r_static[i]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_d;
        end
    end

    always_comb begin
        w_rmux = '0;
        case (w_word)
            WordCtrl:     w_rmux[0] = r_en;
            WordPrescale: w_rmux[PRESCALE_WIDTH-1:0] = r_prescale;
            WordMode:     w_rmux[CHANNELS-1:0] = r_mode;
            WordStatic:   w_rmux[CHANNELS-1:0] = r_static;
            WordStatus: begin
                w_rmux[PWM_WIDTH-1:0] = r_pwm_cnt;
                w_rmux[31]            = r_en;
            end
            default: ;
        endcase
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_word == (WordDuty0 + 6'(i))) begin
                w_rmux[PWM_WIDTH-1:0] = r_duty[i];
            end
        end
    end

    // The sample is taken on acceptance and published one cycle later, so read_data only
    // changes when a read completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rbusy   <= 1'b0;
            r_rsample <= '0;
            r_rdata   <= '0;
        end else if (w_rd_accept) begin
            r_rbusy   <= 1'b1;
            r_rsample <= w_rmux;
        end else if (r_rbusy) begin
            r_rbusy <= 1'b0;
            r_rdata <= r_rsample;
        end
    end

    assign read_data = r_rdata;
    assign rbusy     = r_rbusy;
    assign led       = r_led;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Self-checking bench for led_pwm_bank: register table, directed PWM/prescale/reset
// sequences and a randomized run against a word-level reference model.
module tb_led_pwm_bank;

    localparam int CH = 6;

    logic          clk = 1'b0;
    logic          resetn;
    logic [7:0]    mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_write;
    logic          mem_read;
    logic [3:0]    byte_enable;
    logic [31:0]   read_data;
    logic          rbusy;
    logic [CH-1:0] led;

    always #5 clk = ~clk;

    led_pwm_bank #(
        .CHANNELS      (CH),
        .PWM_WIDTH     (8),
        .PRESCALE_WIDTH(16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .byte_enable(byte_enable),
        .read_data  (read_data),
        .rbusy      (rbusy),
        .led        (led)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge with the strobes idle.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        mem_addr    = a;
        mem_wdata   = d;
        byte_enable = be;
        mem_write   = 1'b1;
        @(negedge clk);
        mem_write   = 1'b0;
        byte_enable = 4'h0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        mem_addr = a;
        mem_read = 1'b1;
        @(negedge clk);
        mem_read = 1'b0;
        check("rbusy_first_cycle", 32'(rbusy), 32'd1);
        @(negedge clk);
        check("rbusy_second_cycle", 32'(rbusy), 32'd0);
        d = read_data;
    endtask

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input bit w, input logic [7:0] a, input logic [31:0] d,
                                    input logic [3:0] be, input logic [31:0] e);
        vec_t v;
        v.is_wr = w;
        v.addr  = a;
        v.data  = d;
        v.be    = be;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    // Reference model: a plain word array plus the count of enabled edges since the
    // counters were last cleared; pwm_cnt follows from integer division.
    logic [31:0] m_regs [64];
    int unsigned m_t;
    logic [CH-1:0] m_led;
    logic        m_rbusy;
    logic [31:0] m_rsample;
    logic [31:0] m_rdata;

    function automatic logic [31:0] m_mask(input int w);
        if (w == 0) return 32'h1;
        if (w == 1) return 32'hFFFF;
        if (w == 2 || w == 3) return 32'h3F;
        if (w >= 8 && w < 8 + CH) return 32'hFF;
        return 32'h0;
    endfunction

    function automatic int m_pwm();
        return int'((m_t / (m_regs[1] + 32'd1)) % 256);
    endfunction

    function automatic logic [31:0] m_read(input int w);
        logic [31:0] r;
        if (w == 4) begin
            r = 32'(m_pwm());
            r[31] = m_regs[0][0];
            return r;
        end
        return m_regs[w];
    endfunction

    function automatic void m_step(input bit wr, input bit rd, input logic [7:0] a,
                                   input logic [31:0] d, input logic [3:0] be);
        int w;
        logic [CH-1:0] led_n;
        logic [31:0] bm;
        w = int'(a[7:2]);
        led_n = '0;
        for (int i = 0; i < CH; i++) begin
            if (m_regs[0][0]) begin
                led_n[i] = m_regs[2][i] ? (int'(m_regs[8+i][7:0]) > m_pwm()) : m_regs[3][i];
            end
        end
        if (rd && !wr && !m_rbusy) begin
            m_rsample = m_read(w);
            m_rbusy   = 1'b1;
        end else if (m_rbusy) begin
            m_rbusy = 1'b0;
            m_rdata = m_rsample;
        end
        if (!m_regs[0][0] || (wr && w == 1 && be != 4'h0)) m_t = 0;
        else m_t++;
        if (wr) begin
            bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            m_regs[w] = ((m_regs[w] & ~bm) | (d & bm)) & m_mask(w);
        end
        m_led = led_n;
    endfunction

    logic [31:0] d;
    int          cnt;
    int          first_low;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        mem_addr    = 8'h0;
        mem_wdata   = 32'h0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        byte_enable = 4'h0;

        add_vec(0, 8'h00, 32'h0, 4'h0, 32'h0);
        add_vec(0, 8'h04, 32'h0, 4'h0, 32'h0);
        add_vec(0, 8'h08, 32'h0, 4'h0, 32'h0);
        add_vec(0, 8'h0C, 32'h0, 4'h0, 32'h0);
        add_vec(0, 8'h10, 32'h0, 4'h0, 32'h0);
        add_vec(0, 8'h20, 32'h0, 4'h0, 32'h0);
        add_vec(1, 8'h04, 32'h12345678, 4'hF, 32'h0);
        add_vec(0, 8'h04, 32'h0, 4'h0, 32'h5678);
        add_vec(1, 8'h04, 32'hAAAABBCC, 4'h1, 32'h0);
        add_vec(0, 8'h04, 32'h0, 4'h0, 32'h56CC);
        add_vec(1, 8'h08, 32'hFFFFFFFF, 4'hF, 32'h0);
        add_vec(0, 8'h08, 32'h0, 4'h0, 32'h3F);
        add_vec(1, 8'h20, 32'h000001FF, 4'h3, 32'h0);
        add_vec(0, 8'h20, 32'h0, 4'h0, 32'hFF);
        add_vec(1, 8'h34, 32'h000000AB, 4'h1, 32'h0);
        add_vec(0, 8'h36, 32'h0, 4'h0, 32'hAB);
        add_vec(1, 8'h38, 32'hFFFFFFFF, 4'hF, 32'h0);
        add_vec(0, 8'h38, 32'h0, 4'h0, 32'h0);
        add_vec(1, 8'h14, 32'hFFFFFFFF, 4'hF, 32'h0);
        add_vec(0, 8'h14, 32'h0, 4'h0, 32'h0);
        add_vec(1, 8'h00, 32'hFFFFFFFF, 4'hE, 32'h0);
        add_vec(0, 8'h00, 32'h0, 4'h0, 32'h0);
        add_vec(1, 8'h0C, 32'h12345667, 4'h1, 32'h0);
        add_vec(0, 8'h0C, 32'h0, 4'h0, 32'h27);
        add_vec(0, 8'h10, 32'h0, 4'h0, 32'h0);

        repeat (2) @(negedge clk);
        check("reset_led", 32'(led), 32'h0);
        check("reset_rbusy", 32'(rbusy), 32'h0);
        check("reset_read_data", read_data, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].data, vecs[i].be);
            end else begin
                bus_read(vecs[i].addr, d);
                check($sformatf("vec%0d_addr%02h", i, vecs[i].addr), d, vecs[i].exp);
            end
        end
        check("table_led_idle", 32'(led), 32'h0);

        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Static mode and byte enables
        bus_write(8'h00, 32'h1, 4'h1);
        bus_write(8'h0C, 32'h2A, 4'h1);
        @(negedge clk);
        check("static_led", 32'(led), 32'h2A);
        bus_write(8'h0C, 32'hFF, 4'h2);
        @(negedge clk);
        check("static_lane1_ignored", 32'(led), 32'h2A);

        // PWM duty: prescale written last so pwm_cnt restarts at 0 just before sampling
        bus_write(8'h08, 32'h1, 4'hF);
        bus_write(8'h20, 32'd64, 4'hF);
        bus_write(8'h04, 32'h0, 4'hF);
        cnt = 0;
        first_low = 0;
        for (int j = 1; j <= 256; j++) begin
            @(negedge clk);
            if (led[0]) cnt++;
            else if (first_low == 0) first_low = j;
        end
        check("duty64_high_count", 32'(cnt), 32'd64);
        check("duty64_first_low", 32'(first_low), 32'd65);

        bus_write(8'h20, 32'd0, 4'hF);
        cnt = 0;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            if (led[0]) cnt++;
        end
        check("duty0_high_count", 32'(cnt), 32'd0);

        bus_write(8'h20, 32'd255, 4'hF);
        cnt = 0;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            if (!led[0]) cnt++;
        end
        check("duty255_low_count", 32'(cnt), 32'd1);

        // Prescale: each read samples two cycles after the previous one
        bus_write(8'h04, 32'd3, 4'hF);
        for (int k = 0; k < 8; k++) begin
            bus_read(8'h10, d);
            check($sformatf("status_prescale3_k%0d", k), d, 32'h80000000 | 32'(k / 2));
        end
        bus_write(8'h04, 32'd3, 4'hF);
        repeat (1020) @(negedge clk);
        bus_read(8'h10, d);
        check("status_before_wrap", d, 32'h800000FF);
        repeat (2) @(negedge clk);
        bus_read(8'h10, d);
        check("status_after_wrap", d, 32'h80000000);
        repeat (37) @(negedge clk);
        bus_write(8'h04, 32'd3, 4'h1);
        bus_read(8'h10, d);
        check("status_after_prescale_rewrite", d, 32'h80000000);

        // Write/read collision: write lands, read dropped
        mem_addr    = 8'h0C;
        mem_wdata   = 32'h15;
        byte_enable = 4'hF;
        mem_write   = 1'b1;
        mem_read    = 1'b1;
        @(negedge clk);
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        byte_enable = 4'h0;
        check("collision_rbusy_n1", 32'(rbusy), 32'h0);
        @(negedge clk);
        check("collision_rbusy_n2", 32'(rbusy), 32'h0);
        bus_read(8'h0C, d);
        check("collision_write_landed", d, 32'h15);

        // A read presented while busy is ignored
        mem_addr = 8'h0C;
        mem_read = 1'b1;
        @(negedge clk);
        check("busy_rbusy_set", 32'(rbusy), 32'h1);
        mem_addr = 8'h08;
        @(negedge clk);
        mem_read = 1'b0;
        check("busy_rbusy_clear", 32'(rbusy), 32'h0);
        check("busy_first_data", read_data, 32'h15);
        @(negedge clk);
        check("busy_second_ignored", 32'(rbusy), 32'h0);
        check("busy_data_held", read_data, 32'h15);

        bus_read(8'h38, d);
        check("unmapped_duty6", d, 32'h0);

        // Reset mid-read during a PWM run
        bus_read(8'h0C, d);
        mem_addr = 8'h08;
        mem_read = 1'b1;
        @(negedge clk);
        mem_read = 1'b0;
        check("midrst_rbusy_before", 32'(rbusy), 32'h1);
        check("midrst_static_led_before", 32'(led & 6'h3E), 32'h14);
        check("midrst_read_data_before", read_data, 32'h15);
        #1 resetn = 1'b0;
        #1;
        check("midrst_led", 32'(led), 32'h0);
        check("midrst_rbusy", 32'(rbusy), 32'h0);
        check("midrst_read_data", read_data, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        for (int w = 0; w < 14; w++) begin
            if (w < 5 || w >= 8) begin
                bus_read(8'(w * 4), d);
                check($sformatf("post_reset_word%0d", w), d, 32'h0);
            end
        end

        // Randomized run against the reference model, from a fresh reset
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int w = 0; w < 64; w++) m_regs[w] = 32'h0;
        m_t       = 0;
        m_led     = '0;
        m_rbusy   = 1'b0;
        m_rsample = 32'h0;
        m_rdata   = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            int     r;
            logic [5:0] word;
            bit     wr;
            bit     rd;
            logic [7:0]  a;
            logic [31:0] dv;
            logic [3:0]  be;
            check($sformatf("rnd%0d_led", c), 32'(led), 32'(m_led));
            check($sformatf("rnd%0d_rbusy", c), 32'(rbusy), 32'(m_rbusy));
            check($sformatf("rnd%0d_read_data", c), read_data, m_rdata);
            r = int'($urandom_range(0, 15));
            if (r < 5) word = 6'(r);
            else if (r < 13) word = 6'(r + 3);
            else if (r == 13) word = 6'h05;
            else if (r == 14) word = 6'h00;
            else word = 6'h02;
            a  = {word, 2'($urandom_range(0, 3))};
            if (word == 6'h01) dv = $urandom_range(0, 3);
            else if (word == 6'h00) dv = ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0;
            else dv = $urandom;
            be = 4'($urandom_range(0, 15));
            wr = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 2) == 0);
            mem_addr    = a;
            mem_wdata   = dv;
            byte_enable = be;
            mem_write   = wr;
            mem_read    = rd;
            m_step(wr, rd, a, dv, be);
            @(negedge clk);
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
